// File: rtl/mul_exec_if.sv
// MUL issue/broadcast bundle between reservation station (master) and the multiply unit (slave).
interface mul_exec_if #(
    parameter int DW = 32,
    parameter int PW = 5,
    parameter int TW = 4
) ();
    logic [PW-1:0] Pa_issue;
    logic [PW-1:0] Pb_issue;
    logic [PW-1:0] Pw_issue;
    logic          valid_op_issue;
    logic [TW-1:0] tag_ROB_issue;
    logic          mul_hi_issue;
    logic [DW-1:0] data_a;
    logic [DW-1:0] data_b;

    logic [PW-1:0] Pw_Result_mul;
    logic          valid_Result_mul;
    logic [DW-1:0] data_Result_mul;
    logic [TW-1:0] tag_ROB_Result_mul;

    modport master (
        output Pa_issue, Pb_issue, Pw_issue, valid_op_issue, tag_ROB_issue,
               mul_hi_issue, data_a, data_b,
        input  Pw_Result_mul, valid_Result_mul, data_Result_mul, tag_ROB_Result_mul
    );

    modport slave (
        input  Pa_issue, Pb_issue, Pw_issue, valid_op_issue, tag_ROB_issue,
               mul_hi_issue, data_a, data_b,
        output Pw_Result_mul, valid_Result_mul, data_Result_mul, tag_ROB_Result_mul
    );
endinterface

// File: rtl/mul_exec_unit.sv
// Pipelined DW-bit multiply unit (STAGES = 2..4) driving the MUL wakeup/writeback broadcast.
// Optional macro MUL_HIGH_EN: carries the full signed 2*DW product and honours mul_hi_issue.
module mul_exec_unit #(
    parameter int STAGES = 3,
    parameter int DW     = 32,
    parameter int PW     = 5,
    parameter int TW     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       freeze_back,
    mul_exec_if.slave  bus,
    output logic       busy
);

`ifdef MUL_HIGH_EN
    localparam int PRODW = 2 * DW;
`else
    localparam int PRODW = DW;
`endif

    logic [STAGES-1:0] valid_r;
    logic [PW-1:0]     pw_r   [STAGES];
    logic [TW-1:0]     tag_r  [STAGES];
    logic [DW-1:0]     a_r;
    logic [DW-1:0]     b_r;
    logic [PRODW-1:0]  prod_r [1:STAGES-1];
    logic [PRODW-1:0]  prod_s;
    logic              advance_s;
    logic              unused_s;

    assign advance_s = ~freeze_back;

`ifdef MUL_HIGH_EN
    logic [STAGES-1:0]       hi_r;
    logic signed [PRODW-1:0] a_ext_s;
    logic signed [PRODW-1:0] b_ext_s;

    assign a_ext_s = {{DW{a_r[DW-1]}}, a_r};
    assign b_ext_s = {{DW{b_r[DW-1]}}, b_r};
    // Low half of the signed product equals the unsigned low product.
    assign prod_s  = a_ext_s * b_ext_s;
    assign unused_s = ^{bus.Pa_issue, bus.Pb_issue};
`else
    assign prod_s   = a_r * b_r;
    assign unused_s = ^{bus.Pa_issue, bus.Pb_issue, bus.mul_hi_issue};
`endif

    // Stage valid bits: flush clears everything (even when frozen), freeze holds, else shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= {STAGES{1'b0}};
        end else if (flush) begin
            valid_r <= {STAGES{1'b0}};
        end else if (advance_s) begin
            valid_r <= {valid_r[STAGES-2:0], bus.valid_op_issue};
        end else begin
            valid_r <= valid_r;
        end
    end

    // Stage payloads load only behind a valid op, so outputs hold the last broadcast value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < STAGES; s++) begin
                pw_r[s]  <= {PW{1'b0}};
                tag_r[s] <= {TW{1'b0}};
            end
            for (int s = 1; s < STAGES; s++) begin
                prod_r[s] <= {PRODW{1'b0}};
            end
            a_r <= {DW{1'b0}};
            b_r <= {DW{1'b0}};
        end else if (advance_s) begin
            if (bus.valid_op_issue) begin
                pw_r[0]  <= bus.Pw_issue;
                tag_r[0] <= bus.tag_ROB_issue;
                a_r      <= bus.data_a;
                b_r      <= bus.data_b;
            end
            if (valid_r[0]) begin
                prod_r[1] <= prod_s;
            end
            for (int s = 1; s < STAGES; s++) begin
                if (valid_r[s-1]) begin
                    pw_r[s]  <= pw_r[s-1];
                    tag_r[s] <= tag_r[s-1];
                end
            end
            for (int s = 2; s < STAGES; s++) begin
                if (valid_r[s-1]) begin
                    prod_r[s] <= prod_r[s-1];
                end
            end
        end
    end

`ifdef MUL_HIGH_EN
    // High-half select bit travels alongside its op.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_r <= {STAGES{1'b0}};
        end else if (advance_s) begin
            if (bus.valid_op_issue) begin
                hi_r[0] <= bus.mul_hi_issue;
            end
            for (int s = 1; s < STAGES; s++) begin
                if (valid_r[s-1]) begin
                    hi_r[s] <= hi_r[s-1];
                end
            end
        end
    end

    assign bus.data_Result_mul = hi_r[STAGES-1] ? prod_r[STAGES-1][PRODW-1:DW]
                                                : prod_r[STAGES-1][DW-1:0];
`else
    assign bus.data_Result_mul = prod_r[STAGES-1];
`endif

    // Frozen cycles suppress the broadcast; the held op goes out on the first un-frozen cycle.
    assign bus.valid_Result_mul   = valid_r[STAGES-1] & advance_s;
    assign bus.Pw_Result_mul      = pw_r[STAGES-1];
    assign bus.tag_ROB_Result_mul = tag_r[STAGES-1];
    assign busy                   = |valid_r;

endmodule

// File: tb/tb_mul_exec_unit.sv
// Directed self-checking bench for mul_exec_unit (STAGES=3), default and MUL_HIGH_EN builds.
module tb_mul_exec_unit;

    logic clk;
    logic rst;
    logic flush;
    logic freeze_back;
    logic busy;
    int   checks;
    int   errors;

    mul_exec_if #(.DW(32), .PW(5), .TW(4)) bus ();

    mul_exec_unit #(.STAGES(3), .DW(32), .PW(5), .TW(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .freeze_back (freeze_back),
        .bus         (bus),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] pw, input logic [3:0] tag,
                         input logic hi, input logic [31:0] a, input logic [31:0] b);
        bus.valid_op_issue = v;
        bus.Pw_issue       = pw;
        bus.Pa_issue       = pw + 5'd1;
        bus.Pb_issue       = pw + 5'd2;
        bus.tag_ROB_issue  = tag;
        bus.mul_hi_issue   = hi;
        bus.data_a         = a;
        bus.data_b         = b;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 4'd0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        flush = 1'b0;
        freeze_back = 1'b0;
        drive(1'b1, 5'd9, 4'd3, 1'b0, 32'd7, 32'd6);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            #2;
            checks++;
            if (bus.valid_Result_mul !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold c=%0d valid=%b busy=%b exp 0/0", c, bus.valid_Result_mul, busy);
            end
            checks++;
            if (bus.data_Result_mul !== 32'd0 || bus.Pw_Result_mul !== 5'd0 || bus.tag_ROB_Result_mul !== 4'd0) begin
                errors++;
                $display("FAIL reset_payload data=%h pw=%0d tag=%0d exp 0", bus.data_Result_mul,
                         bus.Pw_Result_mul, bus.tag_ROB_Result_mul);
            end
        end
        idle();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            #2;
            checks++;
            if (bus.valid_Result_mul !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_after c=%0d valid=%b busy=%b exp 0/0", c, bus.valid_Result_mul, busy);
            end
        end
    endtask

    task automatic test_single();
        logic exp_v;
        logic exp_b;
        for (int c = 0; c < 7; c++) begin
            next_cycle();
            if (c == 0) drive(1'b1, 5'd9, 4'd3, 1'b0, 32'd7, 32'd6);
            else        idle();
            #2;
            exp_v = (c == 3);
            exp_b = (c >= 1 && c <= 3);
            checks++;
            if (bus.valid_Result_mul !== exp_v) begin
                errors++;
                $display("FAIL single_valid c=%0d got %b exp %b", c, bus.valid_Result_mul, exp_v);
            end
            checks++;
            if (busy !== exp_b) begin
                errors++;
                $display("FAIL single_busy c=%0d got %b exp %b", c, busy, exp_b);
            end
            if (c >= 3) begin
                checks++;
                if (bus.data_Result_mul !== 32'd42 || bus.Pw_Result_mul !== 5'd9 || bus.tag_ROB_Result_mul !== 4'd3) begin
                    errors++;
                    $display("FAIL single_payload c=%0d data=%0d pw=%0d tag=%0d exp 42/9/3", c,
                             bus.data_Result_mul, bus.Pw_Result_mul, bus.tag_ROB_Result_mul);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a_t [4];
        logic [31:0] b_t [4];
        logic [31:0] r_t [4];
        logic        exp_v;
        a_t[0] = 32'd2;          b_t[0] = 32'd3;          r_t[0] = 32'd6;
        a_t[1] = 32'hFFFF_FFFF;  b_t[1] = 32'd2;          r_t[1] = 32'hFFFF_FFFE;
        a_t[2] = 32'd0;          b_t[2] = 32'd5;          r_t[2] = 32'd0;
        a_t[3] = 32'h0001_0000;  b_t[3] = 32'h0001_0000;  r_t[3] = 32'd0;
        for (int c = 0; c < 9; c++) begin
            next_cycle();
            if (c < 4) drive(1'b1, 5'd12, 4'(c + 8), 1'b0, a_t[c], b_t[c]);
            else       idle();
            #2;
            exp_v = (c >= 3 && c <= 6);
            checks++;
            if (bus.valid_Result_mul !== exp_v) begin
                errors++;
                $display("FAIL b2b_valid c=%0d got %b exp %b", c, bus.valid_Result_mul, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (bus.data_Result_mul !== r_t[c-3] || bus.tag_ROB_Result_mul !== 4'(c + 5)
                    || bus.Pw_Result_mul !== 5'd12) begin
                    errors++;
                    $display("FAIL b2b_payload c=%0d data=%h tag=%0d pw=%0d exp %h/%0d/12", c,
                             bus.data_Result_mul, bus.tag_ROB_Result_mul, bus.Pw_Result_mul,
                             r_t[c-3], c + 5);
                end
            end
        end
    endtask

    task automatic test_freeze();
        logic exp_v;
        logic exp_b;
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            if (c == 0)      drive(1'b1, 5'd7, 4'd5, 1'b0, 32'd3, 32'd3);
            else if (c == 3) drive(1'b1, 5'd1, 4'd1, 1'b0, 32'd100, 32'd100);
            else             idle();
            freeze_back = (c == 3 || c == 4);
            #2;
            exp_v = (c == 5);
            exp_b = (c >= 1 && c <= 5);
            checks++;
            if (bus.valid_Result_mul !== exp_v) begin
                errors++;
                $display("FAIL freeze_valid c=%0d got %b exp %b", c, bus.valid_Result_mul, exp_v);
            end
            checks++;
            if (busy !== exp_b) begin
                errors++;
                $display("FAIL freeze_busy c=%0d got %b exp %b", c, busy, exp_b);
            end
            if (c == 5) begin
                checks++;
                if (bus.data_Result_mul !== 32'd9 || bus.Pw_Result_mul !== 5'd7 || bus.tag_ROB_Result_mul !== 4'd5) begin
                    errors++;
                    $display("FAIL freeze_payload data=%0d pw=%0d tag=%0d exp 9/7/5",
                             bus.data_Result_mul, bus.Pw_Result_mul, bus.tag_ROB_Result_mul);
                end
            end
        end
        freeze_back = 1'b0;
    endtask

    task automatic test_flush();
        logic exp_b;
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            if (c == 0)      drive(1'b1, 5'd2, 4'd1, 1'b0, 32'd5, 32'd5);
            else if (c == 1) drive(1'b1, 5'd3, 4'd2, 1'b0, 32'd6, 32'd6);
            else if (c == 2) drive(1'b1, 5'd4, 4'd3, 1'b0, 32'd7, 32'd7);
            else             idle();
            flush = (c == 2);
            #2;
            exp_b = (c == 1 || c == 2);
            checks++;
            if (bus.valid_Result_mul !== 1'b0) begin
                errors++;
                $display("FAIL flush_valid c=%0d got %b exp 0", c, bus.valid_Result_mul);
            end
            checks++;
            if (busy !== exp_b) begin
                errors++;
                $display("FAIL flush_busy c=%0d got %b exp %b", c, busy, exp_b);
            end
        end
        // Flush together with freeze still empties the pipeline.
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            if (c == 0) drive(1'b1, 5'd6, 4'd6, 1'b0, 32'd9, 32'd9);
            else        idle();
            flush       = (c == 1);
            freeze_back = (c == 1);
            #2;
            exp_b = (c == 1);
            checks++;
            if (bus.valid_Result_mul !== 1'b0 || busy !== exp_b) begin
                errors++;
                $display("FAIL flush_freeze c=%0d valid=%b busy=%b exp 0/%b", c,
                         bus.valid_Result_mul, busy, exp_b);
            end
        end
        flush = 1'b0;
        freeze_back = 1'b0;
    endtask

    task automatic test_mul_high();
        logic [31:0] r_t [3];
        logic        exp_v;
`ifdef MUL_HIGH_EN
        r_t[0] = 32'hFFFF_FFFF;
        r_t[1] = 32'h3FFF_FFFF;
`else
        r_t[0] = 32'h0000_0000;
        r_t[1] = 32'h0000_0001;
`endif
        r_t[2] = 32'h0000_0000;
        for (int c = 0; c < 7; c++) begin
            next_cycle();
            if (c == 0)      drive(1'b1, 5'd20, 4'd10, 1'b1, 32'h8000_0000, 32'd2);
            else if (c == 1) drive(1'b1, 5'd21, 4'd11, 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
            else if (c == 2) drive(1'b1, 5'd22, 4'd12, 1'b0, 32'h8000_0000, 32'd2);
            else             idle();
            #2;
            exp_v = (c >= 3 && c <= 5);
            checks++;
            if (bus.valid_Result_mul !== exp_v) begin
                errors++;
                $display("FAIL mulhi_valid c=%0d got %b exp %b", c, bus.valid_Result_mul, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (bus.data_Result_mul !== r_t[c-3]) begin
                    errors++;
                    $display("FAIL mulhi_data c=%0d got %h exp %h", c, bus.data_Result_mul, r_t[c-3]);
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        for (int c = 0; c < 7; c++) begin
            next_cycle();
            if (c == 0) drive(1'b1, 5'd30, 4'd14, 1'b0, 32'd11, 32'd11);
            else        idle();
            rst = (c != 1);
            #2;
            checks++;
            if (bus.valid_Result_mul !== 1'b0 || busy !== ((c == 0) ? 1'b0 : 1'b0)) begin
                errors++;
                $display("FAIL midop_reset c=%0d valid=%b busy=%b exp 0/0", c, bus.valid_Result_mul, busy);
            end
            if (c == 1) begin
                checks++;
                if (bus.data_Result_mul !== 32'd0 || bus.Pw_Result_mul !== 5'd0) begin
                    errors++;
                    $display("FAIL midop_payload data=%h pw=%0d exp 0/0", bus.data_Result_mul, bus.Pw_Result_mul);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_freeze();
        test_flush();
        test_mul_high();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
